// File: rtl/alu_nzcv.sv
// alu_nzcv: N-bit two-operand ALU (add, subtract, AND, OR) that produces
// ARM-style NZCV condition flags. The result and the flags are registered,
// so each operation appears at the outputs one clock after its inputs.
module alu_nzcv #(
    parameter int unsigned N = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [1:0]   i_alu_ctrl,
    output logic [N-1:0] o_result,
    output logic [3:0]   o_nzcv
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } op_t;

    op_t          op;
    logic [N-1:0] b_eff;
    logic         carry_in;
    logic [N:0]   sum;
    logic [N-1:0] result_next;
    logic         c_next;
    logic         v_next;
    logic [3:0]   nzcv_next;

    // Shared adder: subtract is a + ~b + 1, so the carry-out means "no borrow".
    always_comb begin
        op       = op_t'(i_alu_ctrl);
        carry_in = (op == OP_SUB);
        b_eff    = carry_in ? ~i_b : i_b;
        sum      = {1'b0, i_a} + {1'b0, b_eff} + (N+1)'(carry_in);
    end

    // Select the result and derive the flags from operands, opcode and result.
    always_comb begin
        result_next = '0;
        c_next      = 1'b0;
        v_next      = 1'b0;
        unique case (op)
            OP_ADD: begin
                result_next = sum[N-1:0];
                c_next      = sum[N];
                v_next      = (i_a[N-1] == i_b[N-1]) && (result_next[N-1] != i_a[N-1]);
            end
            OP_SUB: begin
                result_next = sum[N-1:0];
                c_next      = sum[N];
                v_next      = (i_a[N-1] != i_b[N-1]) && (result_next[N-1] != i_a[N-1]);
            end
            OP_AND: result_next = i_a & i_b;
            OP_OR:  result_next = i_a | i_b;
            default: result_next = '0;
        endcase
        nzcv_next = {result_next[N-1], (result_next == '0), c_next, v_next};
    end

    // Output register; reset clears result and all flags (Z included).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_result <= '0;
            o_nzcv   <= '0;
        end else begin
            o_result <= result_next;
            o_nzcv   <= nzcv_next;
        end
    end

endmodule

// File: tb/tb_alu_nzcv.sv
// tb_alu_nzcv: directed, table-driven checks of alu_nzcv at N = 32, plus
// hand-written sequences for reset, input hold between edges and mid-stream reset.
module tb_alu_nzcv;

    localparam int unsigned N = 32;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [1:0]   ctrl;
    logic [N-1:0] result;
    logic [3:0]   nzcv;

    int vectors    = 0;
    int miscompares = 0;

    alu_nzcv #(.N(N)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_a        (a),
        .i_b        (b),
        .i_alu_ctrl (ctrl),
        .o_result   (result),
        .o_nzcv     (nzcv)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] exp_result;
        logic [3:0]   exp_nzcv;
        string        name;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [N-1:0] exp_r, input logic [3:0] exp_f);
        vectors++;
        if (result !== exp_r || nzcv !== exp_f) begin
            miscompares++;
            $display("FAIL %s: got result=%h nzcv=%b, expected result=%h nzcv=%b",
                     name, result, nzcv, exp_r, exp_f);
        end
    endtask

    // Safety net: the run must never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{2'b00, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1000, "add_0_ffff"};
        vecs[1]  = '{2'b00, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0110, "add_wrap_zero"};
        vecs[2]  = '{2'b00, 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 4'b0000, "add_ripple"};
        vecs[3]  = '{2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001, "add_pos_ovf"};
        vecs[4]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 4'b0111, "add_neg_ovf"};
        vecs[5]  = '{2'b01, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0110, "sub_0_0"};
        vecs[6]  = '{2'b01, 32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 4'b0010, "sub_borrow_chain"};
        vecs[7]  = '{2'b01, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'b1000, "sub_0_1"};
        vecs[8]  = '{2'b01, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011, "sub_neg_ovf"};
        vecs[9]  = '{2'b01, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 4'b1001, "sub_pos_ovf"};
        vecs[10] = '{2'b01, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 4'b1000, "sub_3_5"};
        vecs[11] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1000, "and_ones"};
        vecs[12] = '{2'b10, 32'hFFFF_FFFF, 32'h7743_3477, 32'h7743_3477, 4'b0000, "and_pattern"};
        vecs[13] = '{2'b10, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0100, "and_zero"};
        vecs[14] = '{2'b10, 32'h8000_0000, 32'h8000_0001, 32'h8000_0000, 4'b1000, "and_no_cv"};
        vecs[15] = '{2'b11, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1000, "or_ones"};
        vecs[16] = '{2'b11, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0100, "or_zero"};
        vecs[17] = '{2'b11, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 4'b0000, "or_merge"};

        // Reset with nonzero inputs clears outputs without any clock edge.
        rst_n = 1'b0;
        a     = 32'h1234_5678;
        b     = 32'h0000_5678;
        ctrl  = 2'b00;
        #3;
        check("reset_immediate", '0, 4'b0000);
        @(posedge clk); #1;
        check("reset_held_over_edge", '0, 4'b0000);

        // Release reset, add 0 + 0: Z set on the first capture.
        a = '0;
        b = '0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("first_capture_zero", '0, 4'b0100);

        // Back-to-back: new operands and opcode every cycle.
        for (int i = 0; i < NV; i++) begin
            ctrl = vecs[i].op;
            a    = vecs[i].a;
            b    = vecs[i].b;
            @(posedge clk); #1;
            check(vecs[i].name, vecs[i].exp_result, vecs[i].exp_nzcv);
        end

        // Inputs changing between edges must not disturb the outputs.
        ctrl = 2'b00;
        a    = 32'h0000_0002;
        b    = 32'h0000_0003;
        #3;
        check("hold_between_edges", 32'h1234_5678, 4'b0000);
        @(posedge clk); #1;
        check("add_2_3", 32'h0000_0005, 4'b0000);

        // Mid-stream reset: pending value discarded, stream resumes after release.
        ctrl = 2'b01;
        a    = 32'h0000_0000;
        b    = 32'h0000_0001;
        @(posedge clk); #1;
        check("pre_reset_sub", 32'hFFFF_FFFF, 4'b1000);
        ctrl = 2'b00;
        a    = 32'h7FFF_FFFF;
        b    = 32'h0000_0001;
        #2;
        rst_n = 1'b0;
        #1;
        check("midstream_reset_immediate", '0, 4'b0000);
        @(posedge clk); #1;
        check("midstream_reset_discard", '0, 4'b0000);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("resume_add_ovf", 32'h8000_0000, 4'b1001);
        ctrl = 2'b11;
        a    = 32'h0000_00F0;
        b    = 32'h0000_000F;
        @(posedge clk); #1;
        check("resume_or", 32'h0000_00FF, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_nzcv.md
# alu_nzcv

Parameterised N-bit two-operand ALU with ARM-style condition flags (Negative, Zero, Carry, oVerflow). It performs add, subtract, bitwise AND and bitwise OR on two operands. Result and flags are registered once per clock. It serves as the execute-stage arithmetic unit and flag source for the datapath's condition logic.

## Interface
- N, default 32: operand and result width in bits; legal for N ≥ 2.
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_a  input  N  operand A.
- i_b  input  N  operand B.
- i_alu_ctrl  input  2  operation select: 00 add, 01 subtract, 10 AND, 11 OR.
- o_result  output  N  registered result.
- o_nzcv  output  4  registered flags: bit 3 N, bit 2 Z, bit 1 C, bit 0 V.

## Operation
- Add (00): sum = i_a + i_b, computed at N+1 bits. Result = sum[N-1:0]. C = sum[N], the unsigned carry-out.
- Subtract (01): computed as i_a + ~i_b + 1 at N+1 bits. Result = low N bits. C = carry-out.
  - C = 1 means no borrow (i_a ≥ i_b unsigned).
  - 0 − 0 therefore gives C = 1.
- AND (10): result = i_a & i_b. C = 0, V = 0.
- OR (11): result = i_a | i_b. C = 0, V = 0.
- N flag = result[N-1] for every operation.
- Z flag = 1 if and only if result == 0, for every operation.
- V flag for add: i_a[N-1] == i_b[N-1] and result[N-1] != i_a[N-1].
- V flag for subtract: i_a[N-1] != i_b[N-1] and result[N-1] != i_a[N-1].
- Result bits wrap modulo 2^N. No saturation.
- Operands are treated as raw bit vectors. Signedness only affects how N and V are interpreted.
- The adder/subtractor uses one shared adder, with B inverted and carry-in = 1 for subtract.
- The flag logic is a pure function of operands, opcode and the computed result.

## Timing
- The next result and flags are computed combinationally from the current inputs.
- On each rising edge of i_clk, o_result and o_nzcv load those values. Latency is 1 cycle.
- Throughput is one operation per cycle. There is no handshake and no enable.
- Inputs must be stable for setup/hold around the rising edge. Input changes between edges have no effect on the outputs.
- Reset: i_rst_n low immediately forces o_result = 0 and o_nzcv = 4'b0000, independent of the clock.
  - Flags are all zero during reset, even though the result is zero; Z is not asserted.
- Reset deassertion: the first capture happens on the first rising edge with i_rst_n high.
- Reset asserted mid-operation discards the value that was about to be captured. There is no pending state.
- An opcode change takes effect on the next edge. There is no cross-cycle interaction; flags are not sticky.

## Test plan
- Reset: drive i_rst_n = 0 with nonzero inputs -> o_result = 0 and o_nzcv = 0000 immediately. Release reset, apply add 0 + 0, one edge -> result 0, nzcv 0100.
- Add:
  - 0 + 0xFFFF_FFFF -> 0xFFFF_FFFF, nzcv 1000.
  - 1 + 0xFFFF_FFFF -> 0, nzcv 0110.
  - 0x0000_FFFF + 1 -> 0x0001_0000, nzcv 0000.
  - 0x7FFF_FFFF + 1 -> 0x8000_0000, nzcv 1001.
- Subtract:
  - 0 − 0 -> 0, nzcv 0110.
  - 0x0001_0000 − 1 -> 0x0000_FFFF, nzcv 0010.
  - 0 − 1 -> 0xFFFF_FFFF, nzcv 1000.
  - 0x8000_0000 − 1 -> 0x7FFF_FFFF, nzcv 0011.
- AND:
  - 0xFFFF_FFFF & 0xFFFF_FFFF -> 0xFFFF_FFFF, nzcv 1000.
  - 0xFFFF_FFFF & 0x7743_3477 -> 0x7743_3477, nzcv 0000.
  - 0 & 0xFFFF_FFFF -> 0, nzcv 0100.
- OR:
  - 0 | 0xFFFF_FFFF -> 0xFFFF_FFFF, nzcv 1000.
  - 0 | 0 -> 0, nzcv 0100.
- Latency and back-to-back: change operands and opcode every cycle -> each output pair appears exactly one edge after its inputs. Assert reset mid-stream -> outputs clear at once, and the stream resumes correctly after release.
